// File: rtl/neuron_acc16.sv
// neuron_acc16: 16-input signed MAC neuron with shift, ReLU and saturation, one slot per 3 phases
module neuron_acc16 #(
  parameter int DW    = 8,
  parameter int ACCW  = 20,
  parameter int SHIFT = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 sel,
  input  logic                 en,
  input  logic signed [DW-1:0] x_in,
  input  logic signed [DW-1:0] w_in,
  input  logic signed [DW-1:0] bias_in,
  output logic        [DW-1:0] y_out,
  output logic                 y_valid,
  output logic                 y_sat
);
  localparam logic signed [ACCW-1:0] YMAX = ACCW'((1 << DW) - 1);
  logic [1:0] phase_q, phase_d;
  logic signed [2*DW-1:0] prod_q, prod_d;
  logic signed [DW-1:0] bias_q;
  logic signed [ACCW-1:0] acc_q, acc_d, t;
  logic [DW-1:0] y_q, y_d;
  logic sat_q, sat_d, valid_q;
  always_comb begin
    phase_d = (phase_q == 2'd2) ? 2'd0 : phase_q + 2'd1;
    prod_d  = x_in * w_in;
    acc_d   = (sel ? {{(ACCW-DW){bias_q[DW-1]}}, bias_q} : acc_q)
              + {{(ACCW-2*DW){prod_q[2*DW-1]}}, prod_q};
    t       = acc_d >>> SHIFT;
    sat_d   = t > YMAX;
    y_d     = t[ACCW-1] ? '0 : sat_d ? YMAX[DW-1:0] : t[DW-1:0];
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      phase_q <= '0;
      prod_q  <= '0;
      bias_q  <= '0;
      acc_q   <= '0;
      y_q     <= '0;
      sat_q   <= 1'b0;
      valid_q <= 1'b0;
    end else begin
      phase_q <= phase_d;
      valid_q <= 1'b0;
      if (phase_q == 2'd1) begin
        prod_q <= prod_d;
        if (sel) bias_q <= bias_in;
      end
      if (phase_q == 2'd2) begin
        acc_q <= acc_d;
        if (en) begin
          y_q     <= y_d;
          sat_q   <= sat_d;
          valid_q <= 1'b1;
        end
      end
    end
  end
  assign y_out   = y_q;
  assign y_sat   = sat_q;
  assign y_valid = valid_q;
endmodule
